// File: rtl/writeback_pkg.sv
// Shared types and helpers for the register-file writeback path.
// The holding-entry struct is sized from the package constants below.
package writeback_pkg;

  localparam int WB_SIZE           = 32;
  localparam int WB_REGISTER_COUNT = 31;

  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int WB_INDEX_W = index_width(WB_REGISTER_COUNT);

  typedef struct packed {
    logic [WB_INDEX_W-1:0] index;
    logic [WB_SIZE-1:0]    data;
  } writeback_entry_t;

endpackage

// File: rtl/writeback_arbiter_rotating_grant.sv
// Pointer-relative selection of up to WRITE_COUNT requests; a request whose
// conflict_mask row hits an earlier grant this cycle is deferred.
module rotating_grant #(
  parameter int SOURCE_COUNT = 4,
  parameter int WRITE_COUNT  = 2,
  parameter int PTR_W        = 2
) (
  input  logic [SOURCE_COUNT-1:0]                   request,
  input  logic [SOURCE_COUNT-1:0][SOURCE_COUNT-1:0] conflict_mask,
  input  logic [PTR_W-1:0]                          rr,
  output logic [SOURCE_COUNT-1:0]                   grant,
  output logic [WRITE_COUNT-1:0]                    slot_valid,
  output logic [WRITE_COUNT-1:0][PTR_W-1:0]         slot_source,
  output logic                                      conflict,
  output logic [PTR_W-1:0]                          next_rr
);

  always_comb begin
    int granted;
    int s;
    logic [PTR_W-1:0] last;
    grant       = '0;
    slot_valid  = '0;
    slot_source = '0;
    conflict    = 1'b0;
    granted     = 0;
    last        = rr;
    for (int k = 0; k < SOURCE_COUNT; k++) begin
      s = int'(rr) + k;
      if (s >= SOURCE_COUNT) s = s - SOURCE_COUNT;
      if (request[s] && granted < WRITE_COUNT) begin
        // Only a deferral with a free slot left counts as a conflict.
        if (|(conflict_mask[s] & grant)) begin
          conflict = 1'b1;
        end else begin
          grant[s]             = 1'b1;
          slot_valid[granted]  = 1'b1;
          slot_source[granted] = PTR_W'(s);
          last                 = PTR_W'(s);
          granted              = granted + 1;
        end
      end
    end
    if (granted == 0)                      next_rr = rr;
    else if (int'(last) == SOURCE_COUNT-1) next_rr = '0;
    else                                   next_rr = last + 1'b1;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Buffers producer results and drives up to WRITE_COUNT conflict-free register
// file writes per cycle. Optional counters: WRITEBACK_ARBITER_STATS_EN.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int SIZE           = WB_SIZE,
  parameter int REGISTER_COUNT = WB_REGISTER_COUNT,
  parameter int SOURCE_COUNT   = 4,
  parameter int WRITE_COUNT    = 2,
  parameter int INDEX_W        = index_width(REGISTER_COUNT)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [SOURCE_COUNT-1:0]               source_valid,
  output logic [SOURCE_COUNT-1:0]               source_ready,
  input  logic [SOURCE_COUNT-1:0][INDEX_W-1:0]  source_index,
  input  logic [SOURCE_COUNT-1:0][SIZE-1:0]     source_data,
  output logic [WRITE_COUNT-1:0]                write_enable,
  output logic [WRITE_COUNT-1:0][INDEX_W-1:0]   write_index,
  output logic [WRITE_COUNT-1:0][SIZE-1:0]      write_data,
  output logic                                  pending
`ifdef WRITEBACK_ARBITER_STATS_EN
  ,
  output logic [31:0]                           write_count,
  output logic [31:0]                           conflict_count
`endif
);

  localparam int PTR_W = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1;

  logic [SOURCE_COUNT-1:0]                   full;
  writeback_entry_t                          held [SOURCE_COUNT];
  logic [PTR_W-1:0]                          rr, next_rr;
  logic [SOURCE_COUNT-1:0]                   grant;
  logic [SOURCE_COUNT-1:0][SOURCE_COUNT-1:0] conflict_mask;
  logic [WRITE_COUNT-1:0]                    slot_valid;
  logic [WRITE_COUNT-1:0][PTR_W-1:0]         slot_source;
  logic                                      conflict;

  always_comb begin
    conflict_mask = '0;
    for (int i = 0; i < SOURCE_COUNT; i++)
      for (int j = 0; j < SOURCE_COUNT; j++)
        conflict_mask[i][j] = (held[i].index == held[j].index);
  end

  rotating_grant #(
    .SOURCE_COUNT (SOURCE_COUNT),
    .WRITE_COUNT  (WRITE_COUNT),
    .PTR_W        (PTR_W)
  ) u_grant (
    .request       (full),
    .conflict_mask (conflict_mask),
    .rr            (rr),
    .grant         (grant),
    .slot_valid    (slot_valid),
    .slot_source   (slot_source),
    .conflict      (conflict),
    .next_rr       (next_rr)
  );

  // A granted buffer drains this edge, so it can take a new result at the same time.
  assign source_ready = ~full | grant;
  assign pending      = (|full) | (|write_enable);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full <= '0;
      rr   <= '0;
      for (int s = 0; s < SOURCE_COUNT; s++) held[s] <= '0;
    end else begin
      rr <= next_rr;
      for (int s = 0; s < SOURCE_COUNT; s++) begin
        if (source_valid[s] && source_ready[s]) begin
          full[s]       <= 1'b1;
          held[s].index <= source_index[s];
          held[s].data  <= source_data[s];
        end else if (grant[s]) begin
          full[s] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_enable <= '0;
      write_index  <= '0;
      write_data   <= '0;
    end else begin
      for (int w = 0; w < WRITE_COUNT; w++) begin
        write_enable[w] <= slot_valid[w];
        write_index[w]  <= slot_valid[w] ? held[slot_source[w]].index : '0;
        write_data[w]   <= slot_valid[w] ? held[slot_source[w]].data  : '0;
      end
    end
  end

`ifdef WRITEBACK_ARBITER_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_count    <= '0;
      conflict_count <= '0;
    end else begin
      write_count    <= write_count + 32'($countones(grant));
      conflict_count <= conflict_count + {31'd0, conflict};
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, latency, rotation, conflicts,
// sustained throughput, out-of-range index and mid-operation reset.
module tb_writeback_arbiter;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       source_valid = '0;
  logic [3:0]       source_ready;
  logic [3:0][4:0]  source_index = '0;
  logic [3:0][31:0] source_data = '0;
  logic [1:0]       write_enable;
  logic [1:0][4:0]  write_index;
  logic [1:0][31:0] write_data;
  logic             pending;
`ifdef WRITEBACK_ARBITER_STATS_EN
  logic [31:0]      write_count;
  logic [31:0]      conflict_count;
`endif

  int checks = 0;
  int failures = 0;

  writeback_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_index (source_index),
    .source_data  (source_data),
    .write_enable (write_enable),
    .write_index  (write_index),
    .write_data   (write_data),
    .pending      (pending)
`ifdef WRITEBACK_ARBITER_STATS_EN
    ,
    .write_count    (write_count),
    .conflict_count (conflict_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    source_valid = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (write_enable !== 2'b00) begin failures++; $display("FAIL reset_we got=%b want=00", write_enable); end
    checks++;
    if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b want=0", pending); end
    checks++;
    if (source_ready !== 4'hF) begin failures++; $display("FAIL reset_ready got=%b want=1111", source_ready); end
    checks++;
    if (write_index !== '0 || write_data !== '0) begin
      failures++; $display("FAIL reset_wdata got=%h/%h want=0", write_index, write_data);
    end
  endtask

  task automatic test_single;
    do_reset();
    source_valid = 4'b0001; source_index[0] = 5'd5; source_data[0] = 32'hDEADBEEF;
    tick();
    source_valid = '0;
    checks++;
    if (write_enable !== 2'b00 || pending !== 1'b1) begin
      failures++; $display("FAIL single_latency got we=%b pend=%b want we=00 pend=1", write_enable, pending);
    end
    tick();
    checks++;
    if (write_enable !== 2'b01 || write_index[0] !== 5'd5 || write_data[0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_write got we=%b idx=%0d data=%h want we=01 idx=5 data=deadbeef",
                           write_enable, write_index[0], write_data[0]);
    end
    checks++;
    if (write_index[1] !== 5'd0 || write_data[1] !== 32'd0) begin
      failures++; $display("FAIL single_port1 got idx=%0d data=%h want 0", write_index[1], write_data[1]);
    end
    tick();
    checks++;
    if (write_enable !== 2'b00 || pending !== 1'b0) begin
      failures++; $display("FAIL single_drain got we=%b pend=%b want 00/0", write_enable, pending);
    end
  endtask

  task automatic test_rotation;
    do_reset();
    source_valid = 4'b0111;
    source_index[0] = 5'd3; source_data[0] = 32'hA0;
    source_index[1] = 5'd4; source_data[1] = 32'hA1;
    source_index[2] = 5'd7; source_data[2] = 32'hA2;
    tick();
    source_valid = '0;
    tick();
    checks++;
    if (write_enable !== 2'b11 || write_index[0] !== 5'd3 || write_index[1] !== 5'd4 ||
        write_data[0] !== 32'hA0 || write_data[1] !== 32'hA1) begin
      failures++; $display("FAIL rot_cycle1 got we=%b idx=%0d,%0d data=%h,%h want 11 3,4 a0,a1",
                           write_enable, write_index[0], write_index[1], write_data[0], write_data[1]);
    end
    tick();
    checks++;
    if (write_enable !== 2'b01 || write_index[0] !== 5'd7 || write_data[0] !== 32'hA2 || write_index[1] !== 5'd0) begin
      failures++; $display("FAIL rot_cycle2 got we=%b idx=%0d,%0d data=%h want 01 7,0 a2",
                           write_enable, write_index[0], write_index[1], write_data[0]);
    end
    // Pointer should now be 3: all four full gives order 3,0 then 1,2.
    source_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      source_index[s] = 5'(20 + s); source_data[s] = 32'hB0 + 32'(s);
    end
    tick();
    source_valid = '0;
    tick();
    checks++;
    if (write_enable !== 2'b11 || write_index[0] !== 5'd23 || write_index[1] !== 5'd20) begin
      failures++; $display("FAIL rot_ptr3 got we=%b idx=%0d,%0d want 11 23,20", write_enable, write_index[0], write_index[1]);
    end
    tick();
    checks++;
    if (write_enable !== 2'b11 || write_index[0] !== 5'd21 || write_index[1] !== 5'd22) begin
      failures++; $display("FAIL rot_ptr1 got we=%b idx=%0d,%0d want 11 21,22", write_enable, write_index[0], write_index[1]);
    end
  endtask

  task automatic test_conflict;
    do_reset();
    source_valid = 4'b0110;
    source_index[1] = 5'd9; source_data[1] = 32'h11;
    source_index[2] = 5'd9; source_data[2] = 32'h22;
    tick();
    source_valid = '0;
    checks++;
    if (source_ready !== 4'b1011) begin failures++; $display("FAIL conf_ready got=%b want=1011", source_ready); end
    tick();
    checks++;
    if (write_enable !== 2'b01 || write_index[0] !== 5'd9 || write_data[0] !== 32'h11) begin
      failures++; $display("FAIL conf_first got we=%b idx=%0d data=%h want 01 9 11", write_enable, write_index[0], write_data[0]);
    end
    tick();
    checks++;
    if (write_enable !== 2'b01 || write_index[0] !== 5'd9 || write_data[0] !== 32'h22) begin
      failures++; $display("FAIL conf_second got we=%b idx=%0d data=%h want 01 9 22", write_enable, write_index[0], write_data[0]);
    end
`ifdef WRITEBACK_ARBITER_STATS_EN
    checks++;
    if (conflict_count !== 32'd1 || write_count !== 32'd2) begin
      failures++; $display("FAIL conf_stats got conflict=%0d writes=%0d want 1 2", conflict_count, write_count);
    end
`endif
    tick();
    checks++;
    if (write_enable !== 2'b00 || pending !== 1'b0) begin
      failures++; $display("FAIL conf_drain got we=%b pend=%b want 00/0", write_enable, pending);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      source_index[s] = 5'(10 + s); source_data[s] = 32'h100 + 32'(s);
    end
    source_valid = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (source_ready !== ((k % 2 == 1) ? 4'b0011 : 4'b1100)) begin
        failures++; $display("FAIL b2b_ready k=%0d got=%b", k, source_ready);
      end
      if (k >= 2) begin
        checks++;
        if (write_enable !== 2'b11 ||
            write_index[0] !== ((k % 2 == 0) ? 5'd10 : 5'd12) ||
            write_index[1] !== ((k % 2 == 0) ? 5'd11 : 5'd13) ||
            write_data[0]  !== ((k % 2 == 0) ? 32'h100 : 32'h102)) begin
          failures++; $display("FAIL b2b_write k=%0d got we=%b idx=%0d,%0d data=%h",
                               k, write_enable, write_index[0], write_index[1], write_data[0]);
        end
      end
    end
    source_valid = '0;
  endtask

  task automatic test_out_of_range;
    do_reset();
    source_valid = 4'b1000; source_index[3] = 5'd31; source_data[3] = 32'h5A;
    tick();
    source_valid = '0;
    tick();
    checks++;
    if (write_enable !== 2'b01 || write_index[0] !== 5'd31 || write_data[0] !== 32'h5A) begin
      failures++; $display("FAIL oor_pass got we=%b idx=%0d data=%h want 01 31 5a", write_enable, write_index[0], write_data[0]);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    source_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      source_index[s] = 5'd3; source_data[s] = 32'hC0 + 32'(s);
    end
    tick();
    source_valid = '0;
    tick();
    checks++;
    if (write_enable !== 2'b01 || write_data[0] !== 32'hC0) begin
      failures++; $display("FAIL mid_pre got we=%b data=%h want 01 c0", write_enable, write_data[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (write_enable !== 2'b00 || write_data !== '0 || write_index !== '0 || pending !== 1'b0) begin
      failures++; $display("FAIL mid_clear got we=%b pend=%b want 00/0", write_enable, pending);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (write_enable !== 2'b00 || pending !== 1'b0) begin
        failures++; $display("FAIL mid_discard k=%0d got we=%b pend=%b want 00/0", k, write_enable, pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_conflict();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
